// File: rtl/vscale_fetch_buffer.sv
// Instruction fetch buffer: issues sequential fetches from fetch_pc and queues
// responses {inst, pc, badmem} in a circular buffer for the decode stage.
module vscale_fetch_buffer #(
    parameter int                 XPR_LEN  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [XPR_LEN-1:0] RESET_PC = 32'h0000_0200
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [XPR_LEN-1:0]           imem_addr,
    input  logic                         imem_wait,
    input  logic [XPR_LEN-1:0]           imem_rdata,
    input  logic                         imem_badmem_e,
    input  logic                         redirect,
    input  logic [XPR_LEN-1:0]           redirect_pc,
    input  logic                         deq_ready,
    output logic                         deq_valid,
    output logic [XPR_LEN-1:0]           deq_inst,
    output logic [XPR_LEN-1:0]           deq_pc,
    output logic                         deq_badmem,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [XPR_LEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XPR_LEN-1:0]   resp_pc_q, resp_pc_d;
    logic                 resp_pending_q, resp_pending_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;

    logic [XPR_LEN-1:0]   inst_mem_q [DEPTH];
    logic [XPR_LEN-1:0]   pc_mem_q   [DEPTH];
    logic                 bad_mem_q  [DEPTH];

    logic [CW:0]          occupancy_s;
    logic                 space_s;
    logic                 accept_s;
    logic                 enq_s;
    logic                 deq_s;

    // An in-flight response already owns a slot, so it counts against space.
    assign occupancy_s = {1'b0, count_q} + {{CW{1'b0}}, resp_pending_q};
    assign space_s     = (occupancy_s < DEPTH_W);

    assign imem_req  = !reset && !redirect && (state_q == ST_RUN) && space_s;
    assign imem_addr = fetch_pc_q;
    assign accept_s  = imem_req && !imem_wait;
    assign enq_s     = resp_pending_q && !redirect;
    assign deq_s     = (count_q != {CW{1'b0}}) && deq_ready && !redirect;

    assign deq_valid  = !reset && (count_q != {CW{1'b0}});
    assign count      = reset ? {CW{1'b0}} : count_q;
    assign deq_inst   = inst_mem_q[head_q];
    assign deq_pc     = pc_mem_q[head_q];
    assign deq_badmem = bad_mem_q[head_q];

    // Fetch PC, response tracking and queue pointer/occupancy next state.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        resp_pc_d      = resp_pc_q;
        resp_pending_d = 1'b0;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            head_d     = {PW{1'b0}};
            tail_d     = {PW{1'b0}};
            count_d    = {CW{1'b0}};
        end else begin
            if (accept_s) begin
                fetch_pc_d     = fetch_pc_q + XPR_LEN'(4);
                resp_pc_d      = fetch_pc_q;
                resp_pending_d = 1'b1;
            end else begin
                resp_pending_d = 1'b0;
            end
            if (enq_s) begin
                tail_d = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (deq_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // RUN/HALT: a queued fault stops fetching until the next redirect.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = ST_RUN;
        end else if (enq_s && imem_badmem_e) begin
            state_d = ST_HALT;
        end else begin
            state_d = state_q;
        end
    end

    // Control state registers; reset has priority over every other update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            fetch_pc_q     <= RESET_PC;
            resp_pc_q      <= {XPR_LEN{1'b0}};
            resp_pending_q <= 1'b0;
            head_q         <= {PW{1'b0}};
            tail_q         <= {PW{1'b0}};
            count_q        <= {CW{1'b0}};
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            resp_pc_q      <= resp_pc_d;
            resp_pending_q <= resp_pending_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
        end
    end

    // Queue storage; contents need no reset because occupancy gates them.
    always_ff @(posedge clk) begin
        if (!reset && enq_s) begin
            inst_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]   <= resp_pc_q;
            bad_mem_q[tail_q]  <= imem_badmem_e;
        end
    end

endmodule

// File: tb/tb_vscale_fetch_buffer.sv
// Directed bench for vscale_fetch_buffer: a one-cycle-latency memory responder
// plus per-scenario tasks with hand-computed expectations.
module tb_vscale_fetch_buffer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_wait;
    logic [31:0] imem_rdata;
    logic        imem_badmem_e;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;
    logic        deq_badmem;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic        s_req, s_dv, s_bad;
    logic [31:0] s_addr, s_pc, s_inst;
    logic [2:0]  s_cnt;
    logic [31:0] fault_addr;

    vscale_fetch_buffer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_wait(imem_wait),
        .imem_rdata(imem_rdata), .imem_badmem_e(imem_badmem_e),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_inst(deq_inst),
        .deq_pc(deq_pc), .deq_badmem(deq_badmem), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Sample outputs mid-cycle, then answer an accepted request after the edge.
    task automatic cycle();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_dv = deq_valid;
        s_pc = deq_pc; s_inst = deq_inst; s_bad = deq_badmem; s_cnt = count;
        acc = s_req && !imem_wait;
        a = s_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            imem_rdata = inst_of(a);
            imem_badmem_e = (a == fault_addr);
        end else begin
            imem_rdata = 32'hDEAD_BEEF;
            imem_badmem_e = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0; imem_wait = 1'b0; deq_ready = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        checks++;
        if ({s_req, s_dv, s_cnt} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got req=%0b dv=%0b cnt=%0d expected 0 0 0", s_req, s_dv, s_cnt);
        end
        reset = 1'b0;
        cycle();
        checks++;
        if ({s_req, s_addr} !== {1'b1, 32'h0000_0200}) begin
            errors++;
            $display("FAIL reset_first_req: got req=%0b addr=%h expected 1 00000200", s_req, s_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        logic        exp_dv;
        do_reset();
        deq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (k == 0) begin
                checks++;
                if ({s_req, s_addr} !== {1'b1, 32'h0000_0200}) begin
                    errors++;
                    $display("FAIL stream_first_req: got req=%0b addr=%h expected 1 00000200", s_req, s_addr);
                end
            end
            exp_dv = (k >= 2);
            checks++;
            if (s_dv !== exp_dv) begin
                errors++;
                $display("FAIL stream_valid[%0d]: got %0b expected %0b", k, s_dv, exp_dv);
            end
            if (k >= 2) begin
                exp_pc = 32'h0000_0200 + 32'(4 * (k - 2));
                checks++;
                if (s_pc !== exp_pc || s_inst !== inst_of(exp_pc) || s_bad !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_entry[%0d]: got pc=%h inst=%h bad=%0b expected pc=%h inst=%h bad=0",
                             k, s_pc, s_inst, s_bad, exp_pc, inst_of(exp_pc));
                end
            end
        end
    endtask

    task automatic test_fill();
        logic [5:0]  req_tab;
        int          cnt_tab [6];
        logic [31:0] exp_pc;
        req_tab = 6'b001111;
        cnt_tab = '{0, 0, 1, 2, 3, 4};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++;
            if (s_req !== req_tab[k] || int'(s_cnt) != cnt_tab[k]) begin
                errors++;
                $display("FAIL fill_state[%0d]: got req=%0b cnt=%0d expected req=%0b cnt=%0d",
                         k, s_req, s_cnt, req_tab[k], cnt_tab[k]);
            end
        end
        deq_ready = 1'b1;
        for (int k = 6; k < 13; k++) begin
            cycle();
            exp_pc = 32'h0000_0200 + 32'(4 * (k - 6));
            checks++;
            if (s_dv !== 1'b1 || s_pc !== exp_pc || s_inst !== inst_of(exp_pc)) begin
                errors++;
                $display("FAIL fill_drain[%0d]: got dv=%0b pc=%h inst=%h expected dv=1 pc=%h",
                         k, s_dv, s_pc, s_inst, exp_pc);
            end
            if (k == 7) begin
                checks++;
                if ({s_req, s_addr} !== {1'b1, 32'h0000_0210}) begin
                    errors++;
                    $display("FAIL fill_resume: got req=%0b addr=%h expected 1 00000210", s_req, s_addr);
                end
            end
        end
    endtask

    task automatic test_wait();
        logic [31:0] exp_pc;
        int          n;
        exp_pc = 32'h0000_0200;
        n = 0;
        do_reset();
        deq_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            imem_wait = (k >= 1 && k <= 3);
            cycle();
            if (k >= 1 && k <= 4) begin
                checks++;
                if ({s_req, s_addr} !== {1'b1, 32'h0000_0204}) begin
                    errors++;
                    $display("FAIL wait_hold[%0d]: got req=%0b addr=%h expected 1 00000204", k, s_req, s_addr);
                end
            end
            if (s_dv) begin
                checks++;
                if (s_pc !== exp_pc || s_inst !== inst_of(exp_pc)) begin
                    errors++;
                    $display("FAIL wait_stream[%0d]: got pc=%h expected %h", k, s_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
        end
        imem_wait = 1'b0;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL wait_delivered: got %0d entries expected 5", n);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_pc;
        do_reset();
        for (int k = 0; k < 4; k++) cycle();
        redirect = 1'b1;
        redirect_pc = 32'h0000_1000;
        cycle();
        checks++;
        if ({s_req, s_cnt} !== {1'b0, 3'd3}) begin
            errors++;
            $display("FAIL redirect_cycle: got req=%0b cnt=%0d expected 0 3", s_req, s_cnt);
        end
        redirect = 1'b0;
        deq_ready = 1'b1;
        cycle();
        checks++;
        if ({s_req, s_addr, s_dv, s_cnt} !== {1'b1, 32'h0000_1000, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL redirect_restart: got req=%0b addr=%h dv=%0b cnt=%0d expected 1 00001000 0 0",
                     s_req, s_addr, s_dv, s_cnt);
        end
        cycle();
        checks++;
        if (s_dv !== 1'b0) begin
            errors++;
            $display("FAIL redirect_gap: got dv=%0b pc=%h expected dv=0", s_dv, s_pc);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            exp_pc = 32'h0000_1000 + 32'(4 * k);
            checks++;
            if (s_dv !== 1'b1 || s_pc !== exp_pc || s_inst !== inst_of(exp_pc)) begin
                errors++;
                $display("FAIL redirect_stream[%0d]: got dv=%0b pc=%h expected dv=1 pc=%h", k, s_dv, s_pc, exp_pc);
            end
        end
    endtask

    task automatic test_fault();
        logic [7:0]  req_tab, dv_tab, bad_tab;
        logic [31:0] exp_pc;
        req_tab = 8'b0000_1111;
        dv_tab  = 8'b0011_1100;
        bad_tab = 8'b0001_0000;
        fault_addr = 32'h0000_0208;
        do_reset();
        deq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (s_req !== req_tab[k] || s_dv !== dv_tab[k]) begin
                errors++;
                $display("FAIL fault_ctrl[%0d]: got req=%0b dv=%0b expected req=%0b dv=%0b",
                         k, s_req, s_dv, req_tab[k], dv_tab[k]);
            end
            if (dv_tab[k]) begin
                exp_pc = 32'h0000_0200 + 32'(4 * (k - 2));
                checks++;
                if (s_pc !== exp_pc || s_bad !== bad_tab[k]) begin
                    errors++;
                    $display("FAIL fault_entry[%0d]: got pc=%h bad=%0b expected pc=%h bad=%0b",
                             k, s_pc, s_bad, exp_pc, bad_tab[k]);
                end
            end
        end
        fault_addr = 32'h0000_0001;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        cycle();
        checks++;
        if ({s_req, s_addr} !== {1'b1, 32'h0000_0100}) begin
            errors++;
            $display("FAIL fault_resume: got req=%0b addr=%h expected 1 00000100", s_req, s_addr);
        end
        cycle();
        cycle();
        checks++;
        if ({s_dv, s_pc, s_bad} !== {1'b1, 32'h0000_0100, 1'b0}) begin
            errors++;
            $display("FAIL fault_after: got dv=%0b pc=%h bad=%0b expected 1 00000100 0", s_dv, s_pc, s_bad);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        deq_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        cycle();
        checks++;
        if ({s_req, s_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_req0: got req=%0b addr=%h expected 1 fffffffc", s_req, s_addr);
        end
        cycle();
        checks++;
        if ({s_req, s_addr} !== {1'b1, 32'h0000_0000}) begin
            errors++;
            $display("FAIL wrap_req1: got req=%0b addr=%h expected 1 00000000", s_req, s_addr);
        end
        cycle();
        checks++;
        if ({s_dv, s_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_deq0: got dv=%0b pc=%h expected 1 fffffffc", s_dv, s_pc);
        end
        cycle();
        checks++;
        if ({s_dv, s_pc} !== {1'b1, 32'h0000_0000}) begin
            errors++;
            $display("FAIL wrap_deq1: got dv=%0b pc=%h expected 1 00000000", s_dv, s_pc);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int k = 0; k < 3; k++) cycle();
        reset = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_4000;
        cycle();
        checks++;
        if ({s_req, s_dv, s_cnt} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL midreset_outputs: got req=%0b dv=%0b cnt=%0d expected 0 0 0", s_req, s_dv, s_cnt);
        end
        reset = 1'b0;
        redirect = 1'b0;
        deq_ready = 1'b1;
        cycle();
        checks++;
        if ({s_req, s_addr, s_dv, s_cnt} !== {1'b1, 32'h0000_0200, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL midreset_restart: got req=%0b addr=%h dv=%0b cnt=%0d expected 1 00000200 0 0",
                     s_req, s_addr, s_dv, s_cnt);
        end
        cycle();
        checks++;
        if (s_dv !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale: got dv=%0b pc=%h expected dv=0", s_dv, s_pc);
        end
        cycle();
        checks++;
        if ({s_dv, s_pc} !== {1'b1, 32'h0000_0200}) begin
            errors++;
            $display("FAIL midreset_first: got dv=%0b pc=%h expected 1 00000200", s_dv, s_pc);
        end
    endtask

    initial begin
        reset = 1'b1; imem_wait = 1'b0; imem_rdata = 32'h0; imem_badmem_e = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0; deq_ready = 1'b0;
        fault_addr = 32'h0000_0001;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_fill();
        test_wait();
        test_redirect();
        test_fault();
        test_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
